// File: rtl/bit_serializer_pkg.sv
// Shared state encoding and default word width for bit_serializer.
// The optional parity stage is enabled by defining SER_PARITY_EN.
package bit_serializer_pkg;
    localparam int DEFAULT_WIDTH = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
endpackage

// File: rtl/ser_bit_counter.sv
// Bit index counter for bit_serializer: clears on accept, saturates at WIDTH-1.
module ser_bit_counter #(
    parameter int WIDTH = 21
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     last
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (!reset)
            idx <= '0;
        else if (clear)
            idx <= '0;
        else if (advance && !last)
            idx <= idx + IW'(1);
    end

    assign last = (idx == LAST_IDX);
endmodule

// File: rtl/bit_serializer.sv
// LSB-first parallel-to-serial converter with gapless back-to-back words.
// Define SER_PARITY_EN to append an even-parity bit after each word's MSB.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
`ifdef SER_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    idx;
    logic             last;
    logic             accept;
    logic             ready_en;

    ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (state == SHIFT),
        .idx     (idx),
        .last    (last)
    );

    // Holds load_ready low during reset and releases it on the first edge out of reset.
    always_ff @(posedge clk) begin
        if (!reset) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    always_comb begin
        load_ready = 1'b0;
        case (state)
            IDLE:    load_ready = ready_en;
            SHIFT:   load_ready = !PAR_ON && (idx == LAST_IDX);
            PARITY:  load_ready = PAR_ON;
            default: load_ready = 1'b0;
        endcase
    end

    assign accept = load_valid && load_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (accept) state_nxt = SHIFT;
            SHIFT: begin
                if (last) begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = accept ? SHIFT : IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: state_nxt = accept ? SHIFT : IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                shreg <= data_in;
            else if (state == SHIFT)
                shreg <= shreg >> 1;
        end
    end

`ifdef SER_PARITY_EN
    logic parity;

    always_ff @(posedge clk) begin
        if (!reset)      parity <= 1'b0;
        else if (accept) parity <= ^data_in;
    end

    assign out = (state == SHIFT) ? shreg[0] : ((state == PARITY) && parity);
`else
    assign out = (state == SHIFT) && shreg[0];
`endif

    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
endmodule
